ysyx_23060236_ifu: RTL and testbench
====================================

YSYX_23060236_IFU -- requirements
Module: ysyx_23060236_ifu

Interface
REQ-001 Parameter RESET_PC, 32'h30000000, address of the first instruction fetch after reset.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 arvalid  output  1  instruction read-address valid.
REQ-005 araddr  output  32  instruction read address.
REQ-006 arready  input  1  memory accepts the address.
REQ-007 rvalid  input  1  read data valid.
REQ-008 rdata  input  32  instruction word.
REQ-009 rresp  input  2  read response; nonzero means access fault.
REQ-010 rready  output  1  IFU accepts read data.
REQ-011 inst  output  32  fetched instruction presented to the IDU.
REQ-012 pc  output  32  address of inst.
REQ-013 inst_fault  output  1  inst came back with nonzero rresp.
REQ-014 idu_valid  output  1  inst/pc/inst_fault valid toward the IDU.
REQ-015 idu_ready  input  1  IDU accepts inst this cycle.
REQ-016 jump_wrong  input  1  misprediction/redirect pulse from the back end.
REQ-017 dnpc  input  32  correct next PC, meaningful only while jump_wrong=1.

Function
REQ-018 The IFU SHALL implement FSM states IDLE, REQ, RESP and HOLD, with one outstanding fetch at most and static pc+4 prediction.
REQ-019 IDLE SHALL transition to REQ unconditionally on the next cycle; jump_wrong SHALL be ignored in IDLE.
REQ-020 In REQ: arvalid=1, araddr=fetch_pc; arvalid&arready SHALL move the FSM to RESP; araddr SHALL stay stable until arready, even on jump_wrong.
REQ-021 In RESP: rready=1; the FSM SHALL remain in RESP until rvalid=1.
REQ-022 RESP with rvalid=1, drop=0 and jump_wrong=0 SHALL latch inst<=rdata, pc<=fetch_pc, inst_fault<=(rresp!=0), fetch_pc<=fetch_pc+4 (mod 2^32), and move the FSM to HOLD.
REQ-023 In HOLD: idu_valid=1, and inst/pc/inst_fault SHALL hold stable until the transfer completes or is squashed.
REQ-024 HOLD with idu_ready=1 and jump_wrong=0 SHALL move the FSM to REQ on the next cycle (fetch latency: arvalid 1 cycle after the handshake).
REQ-025 HOLD with jump_wrong=1 SHALL squash the held instruction regardless of idu_ready: idu_valid=0 next cycle, fetch_pc<=dnpc, FSM to REQ.
REQ-026 jump_wrong in REQ, or in RESP without rvalid, SHALL set drop<=1 and redirect_pc<=dnpc; a later jump_wrong before the drop resolves SHALL overwrite redirect_pc.
REQ-027 RESP with rvalid=1 and drop=1 SHALL discard rdata, clear drop, set fetch_pc<=(jump_wrong ? dnpc : redirect_pc), and move the FSM to REQ; idu_valid SHALL stay 0.
REQ-028 RESP with rvalid=1, drop=0 and jump_wrong=1 SHALL discard rdata and set fetch_pc<=dnpc, with the FSM moving to REQ.
REQ-029 A faulting response (rresp!=0) SHALL still be forwarded, with inst=rdata and inst_fault=1; fetch_pc SHALL advance by 4.
REQ-030 arvalid, rready and idu_valid SHALL be decoded from the state register only and SHALL NOT depend combinationally on any input.
REQ-031 No instruction SHALL ever be presented twice, and none SHALL be presented after a jump_wrong that preceded its response.

Reset
REQ-032 While reset=1, the IFU SHALL set state=IDLE, fetch_pc=RESET_PC, redirect_pc=RESET_PC, drop=0, inst=0, pc=RESET_PC, inst_fault=0.
REQ-033 While reset=1, arvalid=0, rready=0 and idu_valid=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it; a late rvalid after reset SHALL be ignored (rready=0 in IDLE/REQ).
REQ-035 The first arvalid SHALL rise on the second cycle after reset deasserts, with araddr=RESET_PC.

Verification
REQ-036 Boot: release reset; arready=1 at once; rvalid one cycle later with rdata=0x00000413, rresp=0; idu_ready=1 -> araddr=0x30000000, then idu_valid with inst=0x00000413, pc=0x30000000, and the next araddr=0x30000004.
REQ-037 Back-pressure: idu_ready=0 for 5 cycles in HOLD -> inst/pc stable, arvalid=0 throughout, and exactly one transfer when idu_ready rises.
REQ-038 Redirect in HOLD: jump_wrong=1, dnpc=0x30000100, idu_ready=1 same cycle -> idu_valid=0 next cycle, the next araddr=0x30000100, and no transfer counted.
REQ-039 Redirect in flight: jump_wrong with dnpc=0x30000200 while in RESP, then a second one with dnpc=0x30000300, then rvalid -> rdata dropped, idu_valid never rises for it, and the next araddr=0x30000300.
REQ-040 Address stall plus redirect: arready=0 for 3 cycles with jump_wrong pulsed (dnpc=0x30000040) in cycle 1 -> araddr stays 0x30000000 until accepted, the response is dropped, and the next araddr=0x30000040.
REQ-041 Fault: rresp=2'b10, rdata=0xDEADBEEF -> idu_valid with inst=0xDEADBEEF, inst_fault=1; the next fetch is at pc+4 with inst_fault=0 on a clean response.

Source files
------------

// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch unit: one outstanding AXI-lite style read, pc+4 prediction,
// and squash/redirect handling toward the IDU.
module ysyx_23060236_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        arvalid,
    output logic [31:0] araddr,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_fault,
    output logic        idu_valid,
    input  logic        idu_ready,
    input  logic        jump_wrong,
    input  logic [31:0] dnpc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (arready) state_d = S_RESP;
            end
            S_RESP: begin
                if (rvalid) begin
                    if (drop_q || jump_wrong) state_d = S_REQ;
                    else state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (jump_wrong || idu_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs come from the state register alone.
    always_comb begin
        arvalid   = (state_q == S_REQ);
        rready    = (state_q == S_RESP);
        idu_valid = (state_q == S_HOLD);
    end

    assign araddr     = fetch_pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_fault = fault_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        drop_d        = drop_q;
        inst_d        = inst_q;
        pc_d          = pc_q;
        fault_d       = fault_q;
        unique case (state_q)
            S_REQ: begin
                if (jump_wrong) begin
                    drop_d        = 1'b1;
                    redirect_pc_d = dnpc;
                end
            end
            S_RESP: begin
                if (!rvalid) begin
                    if (jump_wrong) begin
                        drop_d        = 1'b1;
                        redirect_pc_d = dnpc;
                    end
                end else if (drop_q) begin
                    // Stale response: the newest redirect wins.
                    drop_d     = 1'b0;
                    fetch_pc_d = jump_wrong ? dnpc : redirect_pc_q;
                end else if (jump_wrong) begin
                    fetch_pc_d = dnpc;
                end else begin
                    inst_d     = rdata;
                    pc_d       = fetch_pc_q;
                    fault_d    = (rresp != 2'b00);
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_HOLD: begin
                if (jump_wrong) fetch_pc_d = dnpc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            drop_q        <= 1'b0;
            inst_q        <= 32'd0;
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            drop_q        <= drop_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Bench for the IFU: directed boot/stall/redirect/fault scenarios, then
// randomized bus and redirect traffic checked against a transaction model.
module tb_ysyx_23060236_ifu;

    localparam logic [31:0] RPC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic        idu_valid;
    logic        idu_ready = 1'b0;
    logic        jump_wrong = 1'b0;
    logic [31:0] dnpc = 32'd0;

    ysyx_23060236_ifu #(.RESET_PC(RPC)) dut (
        .clock      (clock),
        .reset      (reset),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rready     (rready),
        .inst       (inst),
        .pc         (pc),
        .inst_fault (inst_fault),
        .idu_valid  (idu_valid),
        .idu_ready  (idu_ready),
        .jump_wrong (jump_wrong),
        .dnpc       (dnpc)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int c0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Transaction-level model: which bus phase we are in, where the next
    // fetch goes, and whether the outstanding fetch has been squashed.
    logic        m_boot, m_ask, m_wait, m_show, m_doom, m_fault;
    logic [31:0] m_next, m_tgt, m_inst, m_pc;

    always @(posedge clock) begin
        if (reset) begin
            m_boot = 1'b1; m_ask = 1'b0; m_wait = 1'b0; m_show = 1'b0;
            m_doom = 1'b0; m_next = RPC; m_tgt = RPC;
            m_inst = 32'd0; m_pc = RPC; m_fault = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_ask  = 1'b1;
        end else if (m_ask) begin
            if (jump_wrong) begin
                m_doom = 1'b1;
                m_tgt  = dnpc;
            end
            if (arready) begin
                m_ask  = 1'b0;
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (!rvalid) begin
                if (jump_wrong) begin
                    m_doom = 1'b1;
                    m_tgt  = dnpc;
                end
            end else begin
                m_wait = 1'b0;
                m_ask  = 1'b1;
                if (m_doom) begin
                    m_doom = 1'b0;
                    m_next = jump_wrong ? dnpc : m_tgt;
                end else if (jump_wrong) begin
                    m_next = dnpc;
                end else begin
                    m_inst  = rdata;
                    m_pc    = m_next;
                    m_fault = (rresp != 2'b00);
                    m_next  = m_next + 32'd4;
                    m_ask   = 1'b0;
                    m_show  = 1'b1;
                end
            end
        end else if (m_show) begin
            if (jump_wrong) begin
                m_next = dnpc;
                m_show = 1'b0;
                m_ask  = 1'b1;
            end else if (idu_ready) begin
                m_show = 1'b0;
                m_ask  = 1'b1;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset && idu_valid && idu_ready && !jump_wrong) xfers++;
    end

    always @(negedge clock) begin
        check("m_arvalid", {31'd0, arvalid}, {31'd0, m_ask});
        check("m_rready", {31'd0, rready}, {31'd0, m_wait});
        check("m_idu_valid", {31'd0, idu_valid}, {31'd0, m_show});
        if (m_ask) check("m_araddr", araddr, m_next);
        if (m_show) begin
            check("m_inst", inst, m_inst);
            check("m_pc", pc, m_pc);
            check("m_fault", {31'd0, inst_fault}, {31'd0, m_fault});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic addr_phase();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic data_phase(input logic [31:0] d, input logic [1:0] r);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = r;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_idu_valid", {31'd0, idu_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, RPC);
        check("rst_fault", {31'd0, inst_fault}, 32'd0);

        // Boot fetch
        reset = 1'b0;
        check("boot_idle_arvalid", {31'd0, arvalid}, 32'd0);
        tick();
        check("boot_arvalid", {31'd0, arvalid}, 32'd1);
        check("boot_araddr", araddr, 32'h3000_0000);
        addr_phase();
        data_phase(32'h0000_0413, 2'b00);
        check("boot_idu_valid", {31'd0, idu_valid}, 32'd1);
        check("boot_inst", inst, 32'h0000_0413);
        check("boot_pc", pc, 32'h3000_0000);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        check("boot_next_araddr", araddr, 32'h3000_0004);
        check("boot_xfers", xfers, 32'd1);

        // Back-pressure in HOLD
        addr_phase();
        data_phase(32'h1111_1111, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("bp_idu_valid", {31'd0, idu_valid}, 32'd1);
            check("bp_inst", inst, 32'h1111_1111);
            check("bp_pc", pc, 32'h3000_0004);
            check("bp_arvalid", {31'd0, arvalid}, 32'd0);
            tick();
        end
        idu_ready = 1'b1;
        c0 = xfers;
        tick();
        idu_ready = 1'b0;
        check("bp_one_xfer", xfers - c0, 32'd1);
        check("bp_next_araddr", araddr, 32'h3000_0008);

        // Redirect while holding
        addr_phase();
        data_phase(32'h2222_2222, 2'b00);
        jump_wrong = 1'b1;
        dnpc = 32'h3000_0100;
        idu_ready = 1'b1;
        c0 = xfers;
        tick();
        jump_wrong = 1'b0;
        idu_ready = 1'b0;
        check("hold_jw_idu_valid", {31'd0, idu_valid}, 32'd0);
        check("hold_jw_xfers", xfers - c0, 32'd0);
        check("hold_jw_araddr", araddr, 32'h3000_0100);

        // Two redirects while the read is in flight
        addr_phase();
        jump_wrong = 1'b1;
        dnpc = 32'h3000_0200;
        tick();
        dnpc = 32'h3000_0300;
        tick();
        jump_wrong = 1'b0;
        check("fly_rready", {31'd0, rready}, 32'd1);
        data_phase(32'h3333_3333, 2'b00);
        check("fly_idu_valid", {31'd0, idu_valid}, 32'd0);
        check("fly_araddr", araddr, 32'h3000_0300);
        tick();
        check("fly_idu_valid2", {31'd0, idu_valid}, 32'd0);

        // Reset during a pending read, then a stray rvalid
        addr_phase();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h9999_9999;
        check("late_rready_idle", {31'd0, rready}, 32'd0);
        tick();
        rvalid = 1'b0;
        check("late_rready_req", {31'd0, rready}, 32'd0);
        check("rst2_arvalid", {31'd0, arvalid}, 32'd1);
        check("rst2_araddr", araddr, RPC);

        // Address stall with a redirect in the first stalled cycle
        jump_wrong = 1'b1;
        dnpc = 32'h3000_0040;
        tick();
        jump_wrong = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall_arvalid", {31'd0, arvalid}, 32'd1);
            check("stall_araddr", araddr, 32'h3000_0000);
            tick();
        end
        addr_phase();
        data_phase(32'hAAAA_AAAA, 2'b00);
        check("stall_idu_valid", {31'd0, idu_valid}, 32'd0);
        check("stall_araddr_next", araddr, 32'h3000_0040);

        // Faulting response, then a clean one
        addr_phase();
        data_phase(32'hDEAD_BEEF, 2'b10);
        check("fault_idu_valid", {31'd0, idu_valid}, 32'd1);
        check("fault_inst", inst, 32'hDEAD_BEEF);
        check("fault_flag", {31'd0, inst_fault}, 32'd1);
        check("fault_pc", pc, 32'h3000_0040);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        check("fault_next_araddr", araddr, 32'h3000_0044);
        addr_phase();
        data_phase(32'h0000_0055, 2'b00);
        check("clean_flag", {31'd0, inst_fault}, 32'd0);
        check("clean_pc", pc, 32'h3000_0044);
        check("clean_inst", inst, 32'h0000_0055);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            arready    = 1'($urandom_range(0, 1));
            rvalid     = rready && ($urandom_range(0, 2) == 0);
            rdata      = $urandom();
            rresp      = ($urandom_range(0, 7) == 0) ?
                         2'($urandom_range(1, 3)) : 2'b00;
            idu_ready  = 1'($urandom_range(0, 1));
            jump_wrong = ($urandom_range(0, 7) == 0);
            dnpc       = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        reset = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        idu_ready = 1'b0;
        jump_wrong = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
